// File: rtl/iq_downconv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : iq_downconv_pkg
// Description : Shared width defaults and derived-width helpers for the
//               IQ down-converter.
// Revision    : 1.0 - initial release
// ============================================================================
package iq_downconv_pkg;

    localparam int c_DIN_W_DEF = 12;
    localparam int c_NCO_W_DEF = 10;
    localparam int c_OUT_W_DEF = 16;
    localparam int c_DEC_DEF   = 8;

    function automatic int prod_w(input int din_w, input int nco_w);
        return din_w + nco_w;
    endfunction

    // Accumulator grows by log2(DEC) bits so a full block of products cannot overflow.
    function automatic int acc_w(input int din_w, input int nco_w, input int dec);
        return din_w + nco_w + $clog2(dec);
    endfunction

endpackage
`default_nettype wire

// File: rtl/iq_mult.sv
`default_nettype none
// ============================================================================
// Module      : iq_mult
// Description : Registered full-width signed multiplier with optional negate.
// Revision    : 1.0 - initial release
// ============================================================================
module iq_mult
    import iq_downconv_pkg::*;
#(
    parameter int A_W    = c_DIN_W_DEF,
    parameter int B_W    = c_NCO_W_DEF,
    parameter bit NEGATE = 1'b0,
    localparam int P_W   = prod_w(A_W, B_W)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_clken,
    input  logic                  i_en,
    input  logic signed [A_W-1:0] i_a,
    input  logic signed [B_W-1:0] i_b,
    output logic signed [P_W-1:0] o_p
);

    logic signed [P_W-1:0] w_a;
    logic signed [P_W-1:0] w_b;
    logic signed [P_W-1:0] w_prod;
    logic signed [P_W-1:0] w_res;
    logic signed [P_W-1:0] r_p;

    // Operands are widened first so the product is formed at full precision.
    assign w_a    = {{B_W{i_a[A_W-1]}}, i_a};
    assign w_b    = {{A_W{i_b[B_W-1]}}, i_b};
    assign w_prod = w_a * w_b;
    assign w_res  = NEGATE ? -w_prod : w_prod;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_p <= '0;
        end else if (i_clken && i_en) begin
            r_p <= w_res;
        end
    end

    assign o_p = r_p;

endmodule
`default_nettype wire

// File: rtl/iq_downconv.sv
`default_nettype none
// ============================================================================
// Module      : iq_downconv
// Description : NCO mixer followed by accumulate-and-dump decimator (I and Q).
// Revision    : 1.0 - initial release
// ============================================================================
module iq_downconv
    import iq_downconv_pkg::*;
#(
    parameter int DIN_W = c_DIN_W_DEF,
    parameter int NCO_W = c_NCO_W_DEF,
    parameter int DEC   = c_DEC_DEF,
    parameter int OUT_W = c_OUT_W_DEF
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    clken,
    input  logic signed [DIN_W-1:0] din,
    input  logic                    din_valid,
    input  logic signed [NCO_W-1:0] nco_sin,
    input  logic signed [NCO_W-1:0] nco_cos,
    input  logic                    nco_valid,
    output logic signed [OUT_W-1:0] i_out,
    output logic signed [OUT_W-1:0] q_out,
    output logic                    dout_valid
);

    localparam int PW = prod_w(DIN_W, NCO_W);
    localparam int AW = acc_w(DIN_W, NCO_W, DEC);
    localparam int CW = $clog2(DEC);
    localparam logic [CW-1:0] c_CNT_LAST = CW'(DEC - 1);

    logic                  w_qual;
    logic signed [PW-1:0]  w_pi;
    logic signed [PW-1:0]  w_pq;
    logic signed [AW-1:0]  w_sum_i;
    logic signed [AW-1:0]  w_sum_q;

    logic                  r_prod_valid;
    logic signed [AW-1:0]  r_acc_i;
    logic signed [AW-1:0]  r_acc_q;
    logic [CW-1:0]         r_cnt;
    logic signed [OUT_W-1:0] r_i_out;
    logic signed [OUT_W-1:0] r_q_out;
    logic                  r_dout_valid;

    assign w_qual = din_valid & nco_valid;

    iq_mult #(
        .A_W    (DIN_W),
        .B_W    (NCO_W),
        .NEGATE (1'b0)
    ) u_mult_i (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clken (clken),
        .i_en    (w_qual),
        .i_a     (din),
        .i_b     (nco_cos),
        .o_p     (w_pi)
    );

    iq_mult #(
        .A_W    (DIN_W),
        .B_W    (NCO_W),
        .NEGATE (1'b1)
    ) u_mult_q (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clken (clken),
        .i_en    (w_qual),
        .i_a     (din),
        .i_b     (nco_sin),
        .o_p     (w_pq)
    );

    assign w_sum_i = r_acc_i + {{CW{w_pi[PW-1]}}, w_pi};
    assign w_sum_q = r_acc_q + {{CW{w_pq[PW-1]}}, w_pq};

    // The dump takes the top OUT_W bits, i.e. an arithmetic shift by AW-OUT_W.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prod_valid <= 1'b0;
            r_acc_i      <= '0;
            r_acc_q      <= '0;
            r_cnt        <= '0;
            r_i_out      <= '0;
            r_q_out      <= '0;
            r_dout_valid <= 1'b0;
        end else if (clken) begin
            r_prod_valid <= w_qual;
            r_dout_valid <= 1'b0;
            if (r_prod_valid) begin
                if (r_cnt == c_CNT_LAST) begin
                    r_i_out      <= w_sum_i[AW-1 -: OUT_W];
                    r_q_out      <= w_sum_q[AW-1 -: OUT_W];
                    r_dout_valid <= 1'b1;
                    r_acc_i      <= '0;
                    r_acc_q      <= '0;
                    r_cnt        <= '0;
                end else begin
                    r_acc_i <= w_sum_i;
                    r_acc_q <= w_sum_q;
                    r_cnt   <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign i_out      = r_i_out;
    assign q_out      = r_q_out;
    assign dout_valid = r_dout_valid;

endmodule
`default_nettype wire

// File: tb/tb_iq_downconv.sv
`default_nettype none
// ============================================================================
// Module      : tb_iq_downconv
// Description : Self-checking bench for iq_downconv against a block-sum model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iq_downconv;

    localparam int DIN_W = 12;
    localparam int NCO_W = 10;
    localparam int DEC   = 8;
    localparam int OUT_W = 16;
    localparam int SH    = DIN_W + NCO_W + $clog2(DEC) - OUT_W;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic clken = 1'b0;
    logic din_valid = 1'b0;
    logic nco_valid = 1'b0;
    logic signed [DIN_W-1:0] din = '0;
    logic signed [NCO_W-1:0] nco_sin = '0;
    logic signed [NCO_W-1:0] nco_cos = '0;
    logic signed [OUT_W-1:0] i_out;
    logic signed [OUT_W-1:0] q_out;
    logic dout_valid;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    iq_downconv #(
        .DIN_W (DIN_W),
        .NCO_W (NCO_W),
        .DEC   (DEC),
        .OUT_W (OUT_W)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .clken      (clken),
        .din        (din),
        .din_valid  (din_valid),
        .nco_sin    (nco_sin),
        .nco_cos    (nco_cos),
        .nco_valid  (nco_valid),
        .i_out      (i_out),
        .q_out      (q_out),
        .dout_valid (dout_valid)
    );

    // Model: sum DEC qualifying products, emit floor(sum/2^SH) one enabled edge later.
    longint m_sum_i = 0, m_sum_q = 0, m_si = 0, m_sq = 0;
    int     m_n = 0;
    bit     m_sched = 1'b0;
    bit     e_dv = 1'b0;
    longint e_i = 0, e_q = 0;

    initial begin
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                m_sum_i = 0; m_sum_q = 0; m_n = 0; m_sched = 1'b0;
                e_dv = 1'b0; e_i = 0; e_q = 0;
            end else if (clken) begin
                e_dv = 1'b0;
                if (m_sched) begin
                    e_i = m_si; e_q = m_sq; e_dv = 1'b1; m_sched = 1'b0;
                end
                if (din_valid && nco_valid) begin
                    m_sum_i = m_sum_i + longint'(din) * longint'(nco_cos);
                    m_sum_q = m_sum_q - longint'(din) * longint'(nco_sin);
                    m_n++;
                    if (m_n == DEC) begin
                        m_si = m_sum_i >>> SH;
                        m_sq = m_sum_q >>> SH;
                        m_sched = 1'b1;
                        m_sum_i = 0; m_sum_q = 0; m_n = 0;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            vectors++;
            if (dout_valid !== e_dv || longint'(i_out) != e_i || longint'(q_out) != e_q
                || $isunknown({i_out, q_out})) begin
                miscompares++;
                $display("FAIL model t=%0t dv=%b/%b i=%0d/%0d q=%0d/%0d (actual/required)",
                         $time, dout_valid, e_dv, i_out, e_i, q_out, e_q);
            end
        end
    end

    task automatic check(input string name, input longint act, input longint req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic wait_dv(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!dout_valid && n < 60);
        if (!dout_valid) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_dv timeout actual=0 required=1");
        end
    endtask

    task automatic set_in(input bit ce, input bit dv, input bit nv,
                          input int d, input int c, input int s);
        clken     = ce;
        din_valid = dv;
        nco_valid = nv;
        din       = DIN_W'(d);
        nco_cos   = NCO_W'(c);
        nco_sin   = NCO_W'(s);
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b1;
    endtask

    function automatic int rand_val(input int w);
        int r;
        r = $urandom_range(0, 7);
        if (r == 0) return -(1 << (w - 1));
        if (r == 1) return (1 << (w - 1)) - 1;
        return int'($urandom_range(0, (1 << w) - 1)) - (1 << (w - 1));
    endfunction

    initial begin
        int n;
        // Continuous tone: first strobe 9 negedges after start, then every 8.
        do_reset();
        set_in(1, 1, 1, 1000, 511, 0);
        wait_dv(n);
        check("first_latency", n, 9);
        check("tone_i", i_out, 7984);
        check("tone_q", q_out, 0);
        wait_dv(n);
        check("tone_period", n, 8);

        // Stall during the dump cycle: strobe held, then one further enabled cycle.
        #1 clken = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("stall_dv_held", dout_valid, 1);
        end
        check("stall_i_held", i_out, 7984);
        #1 clken = 1'b1;
        @(negedge clk);
        check("stall_dv_release", dout_valid, 0);

        // Reset mid-block after 5 products.
        wait_dv(n);
        repeat (5) @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("reset_i", i_out, 0);
        check("reset_dv", dout_valid, 0);
        @(negedge clk); #1 reset_n = 1'b1;
        wait_dv(n);
        check("post_reset_latency", n, 9);
        check("post_reset_i", i_out, 7984);

        // din_valid gap of 3 cycles after the 4th sample.
        do_reset();
        set_in(1, 1, 1, 1000, 511, 0);
        repeat (4) @(negedge clk);
        #1 din_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1 din_valid = 1'b1;
        wait_dv(n);
        check("gap_latency", n, 5);
        check("gap_i", i_out, 7984);
        @(negedge clk);
        check("gap_single_strobe", dout_valid, 0);

        // Most-negative corner.
        do_reset();
        set_in(1, 1, 1, -2048, -512, -512);
        wait_dv(n);
        check("corner_i", i_out, 16384);
        check("corner_q", q_out, -16384);

        // NCO not valid: nothing accumulates.
        do_reset();
        set_in(1, 1, 0, 1000, 511, 0);
        repeat (20) @(negedge clk);
        check("nco_invalid_dv", dout_valid, 0);
        #1 nco_valid = 1'b1;
        wait_dv(n);
        check("nco_invalid_fresh_latency", n, 9);

        // Randomized traffic with occasional resets.
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk); #1;
            reset_n = ($urandom_range(0, 499) != 0);
            set_in($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 80,
                   $urandom_range(0, 99) < 85, rand_val(DIN_W),
                   rand_val(NCO_W), rand_val(NCO_W));
        end
        @(negedge clk); #1 reset_n = 1'b1;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
